disp_scan_ctrl: RTL and testbench

- Scan controller directly upstream of the 4:1 x 4-bit digit mux in the DisplaySch IP.
- Divides the system clock down to a digit-refresh rate and drives the mux select `sel[1:0]`.
- Drives the active-low anode enables `an[3:0]` for a 4-digit seven-segment display.
- Double-buffers a 16-bit display word and presents it as four nibbles `d0..d3`, which feed mux inputs I0..I3. New values take effect only at frame boundaries, so the display never tears.

---
 rtl/disp_pkg.sv | 29 ++
 rtl/disp_prescaler.sv | 37 +++
 rtl/disp_scan_ctrl.sv | 160 ++++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the display scan controller.
// Optional feature macro used by the design: DISP_GHOST_BLANK_EN.
package disp_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;

    typedef logic [DIGIT_W-1:0]            digit_t;
    typedef logic [DIGIT_W*NUM_DIGITS-1:0] disp_word_t;

    typedef enum logic [0:0] {
        DISPLAY = 1'b0,
        BLANK   = 1'b1
    } scan_state_e;

    // One-hot anode pattern (active high) for a digit index.
    function automatic logic [NUM_DIGITS-1:0] sel_onehot(input logic [1:0] idx);
        logic [NUM_DIGITS-1:0] oh;
        case (idx)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/disp_prescaler.sv
// Digit-slot prescaler: counts 0..PRESCALE_DIV-1 and flags the last cycle.
module disp_prescaler #(
    parameter int unsigned PRESCALE_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(PRESCALE_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_MAX);

    // Next count: wrap to zero after the last cycle of a slot.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Four-digit seven-segment scan controller with a frame-synchronous
// double-buffered display word. Macro DISP_GHOST_BLANK_EN adds a blanking
// interval at the start of every digit slot to suppress ghosting.
module disp_scan_ctrl #(
    parameter int unsigned PRESCALE_DIV = 100000
`ifdef DISP_GHOST_BLANK_EN
    ,
    parameter int unsigned DEAD_CYCLES  = 16
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [15:0] upd_data,
    input  logic [3:0]  en_mask,
    output logic [1:0]  sel,
    output logic [3:0]  an,
    output logic [3:0]  d0,
    output logic [3:0]  d1,
    output logic [3:0]  d2,
    output logic [3:0]  d3,
    output logic        frame_start
);

    import disp_pkg::*;

`ifdef DISP_GHOST_BLANK_EN
    localparam int unsigned DEAD_W = $clog2(DEAD_CYCLES + 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
    localparam scan_state_e RESET_STATE = BLANK;
    logic [DEAD_W-1:0] dead_q;
    logic [DEAD_W-1:0] dead_d;
`else
    localparam scan_state_e RESET_STATE = DISPLAY;
`endif

    logic        tick;
    logic        wrap;
    logic [1:0]  sel_q, sel_d;
    logic [3:0]  an_q, an_d;
    disp_word_t  act_q, act_d;
    disp_word_t  pend_q, pend_d;
    logic        pend_full_q, pend_full_d;
    logic        frame_start_q, frame_start_d;
    scan_state_e state_q, state_d;

    disp_prescaler #(.PRESCALE_DIV(PRESCALE_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign wrap = tick && (sel_q == 2'd3);

    // Digit index, frame pulse and double-buffer handshake. The pending word
    // is only ever moved to the active buffer at a frame wrap; a word offered
    // on the wrap cycle itself lands in pending and waits for the next wrap.
    always_comb begin
        sel_d         = sel_q;
        act_d         = act_q;
        pend_d        = pend_q;
        pend_full_d   = pend_full_q;
        frame_start_d = wrap;
        if (tick) begin
            sel_d = sel_q + 2'd1;
        end else begin
            sel_d = sel_q;
        end
        if (wrap && pend_full_q) begin
            act_d       = pend_q;
            pend_full_d = 1'b0;
        end else if (upd_valid && !pend_full_q) begin
            pend_d      = upd_data;
            pend_full_d = 1'b1;
        end else begin
            pend_full_d = pend_full_q;
        end
    end

    // Scan FSM: anode drive follows the next digit index so anode and sel
    // switch on the same edge; the mask is applied every cycle.
    always_comb begin
        state_d = state_q;
        an_d    = an_q;
`ifdef DISP_GHOST_BLANK_EN
        dead_d  = dead_q;
        case (state_q)
            DISPLAY: begin
                if (tick) begin
                    state_d = BLANK;
                    dead_d  = '0;
                    an_d    = 4'hF;
                end else begin
                    an_d = ~(sel_onehot(sel_d) & en_mask);
                end
            end
            BLANK: begin
                if (dead_q == DEAD_LAST) begin
                    state_d = DISPLAY;
                    an_d    = ~(sel_onehot(sel_d) & en_mask);
                end else begin
                    dead_d = dead_q + DEAD_W'(1);
                    an_d   = 4'hF;
                end
            end
            default: begin
                state_d = BLANK;
                dead_d  = '0;
                an_d    = 4'hF;
            end
        endcase
`else
        case (state_q)
            DISPLAY: an_d = ~(sel_onehot(sel_d) & en_mask);
            default: begin
                state_d = DISPLAY;
                an_d    = ~(sel_onehot(sel_d) & en_mask);
            end
        endcase
`endif
    end

    // State and output registers; reset discards any pending word.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q         <= 2'd0;
            an_q          <= 4'hF;
            act_q         <= '0;
            pend_q        <= '0;
            pend_full_q   <= 1'b0;
            frame_start_q <= 1'b0;
            state_q       <= RESET_STATE;
`ifdef DISP_GHOST_BLANK_EN
            dead_q        <= '0;
`endif
        end else begin
            sel_q         <= sel_d;
            an_q          <= an_d;
            act_q         <= act_d;
            pend_q        <= pend_d;
            pend_full_q   <= pend_full_d;
            frame_start_q <= frame_start_d;
            state_q       <= state_d;
`ifdef DISP_GHOST_BLANK_EN
            dead_q        <= dead_d;
`endif
        end
    end

    assign upd_ready   = ~pend_full_q;
    assign sel         = sel_q;
    assign an          = an_q;
    assign d0          = act_q[3:0];
    assign d1          = act_q[7:4];
    assign d2          = act_q[11:8];
    assign d3          = act_q[15:12];
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl (default build and DISP_GHOST_BLANK_EN).
module tb_disp_scan_ctrl;

`ifdef DISP_GHOST_BLANK_EN
    localparam int P  = 8;
    localparam int DC = 2;
`else
    localparam int P  = 4;
    localparam int DC = 0;
`endif
    localparam int FRAME = 4 * P;

    logic        clk;
    logic        rst;
    logic        upd_valid;
    logic        upd_ready;
    logic [15:0] upd_data;
    logic [3:0]  en_mask;
    logic [1:0]  sel;
    logic [3:0]  an;
    logic [3:0]  d0, d1, d2, d3;
    logic        frame_start;

`ifdef DISP_GHOST_BLANK_EN
    disp_scan_ctrl #(.PRESCALE_DIV(P), .DEAD_CYCLES(DC)) dut (
`else
    disp_scan_ctrl #(.PRESCALE_DIV(P)) dut (
`endif
        .clk         (clk),
        .rst         (rst),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_data    (upd_data),
        .en_mask     (en_mask),
        .sel         (sel),
        .an          (an),
        .d0          (d0),
        .d1          (d1),
        .d2          (d2),
        .d3          (d3),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic [1:0]  sel;
        logic [3:0]  an;
        logic [15:0] d;
        logic        fs;
    } exp_t;

    typedef struct {
        logic [3:0] mask;
        int         ncyc;
        logic [1:0] sel;
        logic [3:0] an;
        logic       fs;
    } vec_t;

    exp_t sbq[$];
    vec_t tbl[$];

    int checks = 0;
    int errors = 0;

    // Reference model: k counts non-reset edges since reset.
    int          k = 0;
    logic [15:0] m_act  = 16'h0000;
    logic [15:0] m_pend = 16'h0000;
    logic        m_full = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h (k=%0d)", name, act, req, k);
        end
    endtask

    function automatic logic [3:0] exp_an(input int kk, input logic [3:0] mask);
        int         sl;
        logic [3:0] oh;
        sl = (kk / P) % 4;
        oh = 4'b0001 << sl;
        if (kk == 0 || (kk % P) < DC) return 4'hF;
        return ~(oh & mask);
    endfunction

    // Apply current inputs for one edge, predict, then compare.
    task automatic step();
        exp_t e;
        exp_t g;
        if (rst) begin
            k = 0; m_act = 16'h0000; m_pend = 16'h0000; m_full = 1'b0;
        end else begin
            k++;
            if ((k % FRAME) == 0 && m_full) begin
                m_act = m_pend; m_full = 1'b0;
            end else if (upd_valid && !m_full) begin
                m_pend = upd_data; m_full = 1'b1;
            end
        end
        e.sel = 2'((k / P) % 4);
        e.an  = exp_an(k, en_mask);
        e.fs  = (k > 0) && ((k % FRAME) == 0);
        e.d   = m_act;
        e.rdy = !m_full;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        g = sbq.pop_front();
        chk("sb_sel", 32'(sel), 32'(g.sel));
        chk("sb_an", 32'(an), 32'(g.an));
        chk("sb_fs", 32'(frame_start), 32'(g.fs));
        chk("sb_d", 32'({d3, d2, d1, d0}), 32'(g.d));
        chk("sb_rdy", 32'(upd_ready), 32'(g.rdy));
    endtask

    // Step at least once, until the frame phase equals ph.
    task automatic run_to_phase(input int ph);
        do step(); while ((k % FRAME) != ph);
    endtask

    initial begin
`ifdef DISP_GHOST_BLANK_EN
        tbl.push_back('{4'hF, 1, 2'd0, 4'hF, 1'b0});
        tbl.push_back('{4'hF, 1, 2'd0, 4'hE, 1'b0});
        tbl.push_back('{4'hF, 6, 2'd1, 4'hF, 1'b0});
        tbl.push_back('{4'hF, 2, 2'd1, 4'hD, 1'b0});
        tbl.push_back('{4'hF, 6, 2'd2, 4'hF, 1'b0});
        tbl.push_back('{4'hF, 2, 2'd2, 4'hB, 1'b0});
        tbl.push_back('{4'hF, 6, 2'd3, 4'hF, 1'b0});
        tbl.push_back('{4'hF, 2, 2'd3, 4'h7, 1'b0});
        tbl.push_back('{4'hF, 6, 2'd0, 4'hF, 1'b1});
        tbl.push_back('{4'hF, 2, 2'd0, 4'hE, 1'b0});
`else
        tbl.push_back('{4'hF, 1, 2'd0, 4'hE, 1'b0});
        tbl.push_back('{4'hF, 3, 2'd1, 4'hD, 1'b0});
        tbl.push_back('{4'hF, 4, 2'd2, 4'hB, 1'b0});
        tbl.push_back('{4'hF, 4, 2'd3, 4'h7, 1'b0});
        tbl.push_back('{4'hF, 3, 2'd3, 4'h7, 1'b0});
        tbl.push_back('{4'hF, 1, 2'd0, 4'hE, 1'b1});
        tbl.push_back('{4'hF, 1, 2'd0, 4'hE, 1'b0});
        tbl.push_back('{4'h3, 3, 2'd1, 4'hD, 1'b0});
        tbl.push_back('{4'h3, 4, 2'd2, 4'hF, 1'b0});
        tbl.push_back('{4'h3, 4, 2'd3, 4'hF, 1'b0});
        tbl.push_back('{4'h3, 4, 2'd0, 4'hE, 1'b1});
`endif

        rst = 1'b1; upd_valid = 1'b0; upd_data = 16'h0000; en_mask = 4'hF;

        // Reset for two cycles.
        step(); step();
        chk("rst_an", 32'(an), 32'h0000000F);
        chk("rst_sel", 32'(sel), 32'h00000000);
        chk("rst_rdy", 32'(upd_ready), 32'h00000001);
        chk("rst_d", 32'({d3, d2, d1, d0}), 32'h00000000);
        rst = 1'b0;

        // Scan sequence and masking from the table.
        for (int i = 0; i < tbl.size(); i++) begin
            en_mask = tbl[i].mask;
            repeat (tbl[i].ncyc) step();
            chk("tbl_sel", 32'(sel), 32'(tbl[i].sel));
            chk("tbl_an", 32'(an), 32'(tbl[i].an));
            chk("tbl_fs", 32'(frame_start), 32'(tbl[i].fs));
        end
        en_mask = 4'hF;

        // Buffered update mid-frame.
        run_to_phase(2 * P);
        upd_valid = 1'b1; upd_data = 16'h1234;
        step();
        chk("upd_rdy_low", 32'(upd_ready), 32'h00000000);
        chk("upd_not_yet", 32'({d3, d2, d1, d0}), 32'h00000000);

        // Back-pressure: hold the next word while pending is full.
        upd_data = 16'hABCD;
        run_to_phase(0);
        chk("upd_d0", 32'(d0), 32'h00000004);
        chk("upd_d1", 32'(d1), 32'h00000003);
        chk("upd_d2", 32'(d2), 32'h00000002);
        chk("upd_d3", 32'(d3), 32'h00000001);
        chk("upd_rdy_back", 32'(upd_ready), 32'h00000001);
        step();
        chk("bp_accept", 32'(upd_ready), 32'h00000000);
        upd_valid = 1'b0;
        run_to_phase(0);
        chk("bp_visible", 32'({d3, d2, d1, d0}), 32'h0000ABCD);

        // Boundary collision: offer on the wrap cycle with pending empty.
        run_to_phase(FRAME - 1);
        upd_valid = 1'b1; upd_data = 16'h5A5A;
        step();
        upd_valid = 1'b0;
        chk("coll_not_bypassed", 32'({d3, d2, d1, d0}), 32'h0000ABCD);
        chk("coll_pending", 32'(upd_ready), 32'h00000000);
        run_to_phase(0);
        chk("coll_applied", 32'({d3, d2, d1, d0}), 32'h00005A5A);

        // Mask change mid-slot reflected on the next cycle.
        run_to_phase(DC + 1);
        en_mask = 4'b0010;
        step();
        chk("mask_off", 32'(an), 32'h0000000F);
        en_mask = 4'hF;
        step();
        chk("mask_on", 32'(an), 32'h0000000E);

        // Reset mid-frame (inside a blanking interval when enabled).
        upd_valid = 1'b1; upd_data = 16'h7777;
        step();
        upd_valid = 1'b0;
        run_to_phase(P + 1);
        rst = 1'b1;
        step();
        chk("mrst_sel", 32'(sel), 32'h00000000);
        chk("mrst_an", 32'(an), 32'h0000000F);
        chk("mrst_rdy", 32'(upd_ready), 32'h00000001);
        chk("mrst_d", 32'({d3, d2, d1, d0}), 32'h00000000);
        rst = 1'b0;
        run_to_phase(0);
        chk("mrst_discard", 32'({d3, d2, d1, d0}), 32'h00000000);
        chk("mrst_fs", 32'(frame_start), 32'h00000001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
